// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU MEM stage, DMA) arbiter in front of a
// synchronous-read data memory manager (1-cycle read latency).
//
// Ports
//   CLK            single clock, rising edge
//   RST            asynchronous active-low reset
//   cpu_req_i/we_i CPU access request / write enable
//   cpu_addr_i     CPU address, cpu_wdata_i CPU store data
//   cpu_rdata_o    CPU load data (valid the cycle after a CPU read grant)
//   cpu_stall_o    freeze for EX/MEM and MEM/WB while the CPU is not served
//   dma_req_i/we_i DMA access request / write enable
//   dma_addr_i     DMA address, dma_wdata_i DMA write data
//   dma_gnt_o      DMA owns the memory this cycle
//   dma_rvalid_o   DMA read data valid, dma_rdata_o DMA read data
//   mem_addr_o     memory address, mem_data_o memory write data
//   mem_wren_o     memory write enable, mem_data_i memory read data
//
// Configuration
//   MEM_ARB_STARVE_GUARD_EN  when defined, a 4-bit starve counter forces a DMA
//                            slot after STARVE_LIM contended CPU wins; when
//                            undefined the CPU always wins contention.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [DATA_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [DATA_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wren_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;
  typedef enum logic [1:0] {S_IDLE, S_CPU_RD, S_DMA_RD} state_t;

  owner_t w_owner;
  state_t r_state, w_state_nxt;
  logic   w_force_dma;

  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_lim
    $error("mem_arbiter: STARVE_LIM must be in 1..15");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] r_starve;

  // The counter stops at STARVE_LIM because reaching it hands the next
  // contended cycle to the DMA, which clears it.
  assign w_force_dma = (r_starve == 4'(STARVE_LIM));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_starve <= 4'd0;
    else      r_starve <= (cpu_req_i && dma_req_i && w_owner == OWN_CPU) ? r_starve + 4'd1 : 4'd0;
  end
`else
  assign w_force_dma = 1'b0;
`endif

  // The CPU wins contention unless the DMA is owed a forced slot.
  always_comb begin
    w_owner = OWN_NONE;
    if (cpu_req_i && !(dma_req_i && w_force_dma)) w_owner = OWN_CPU;
    else if (dma_req_i)                           w_owner = OWN_DMA;
  end

  assign mem_addr_o  = (w_owner == OWN_CPU) ? cpu_addr_i  : (w_owner == OWN_DMA) ? dma_addr_i  : '0;
  assign mem_data_o  = (w_owner == OWN_CPU) ? cpu_wdata_i : (w_owner == OWN_DMA) ? dma_wdata_i : '0;
  assign mem_wren_o  = (w_owner == OWN_CPU) ? cpu_we_i    : (w_owner == OWN_DMA) ? dma_we_i    : 1'b0;
  assign cpu_stall_o = cpu_req_i && (w_owner != OWN_CPU);
  assign dma_gnt_o   = (w_owner == OWN_DMA);

  // Remembers who issued last cycle's read so the returning data is steered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_owner == OWN_CPU && !cpu_we_i)      w_state_nxt = S_CPU_RD;
    else if (w_owner == OWN_DMA && !dma_we_i) w_state_nxt = S_DMA_RD;
  end

  assign dma_rvalid_o = (r_state == S_DMA_RD);
  assign dma_rdata_o  = (r_state == S_DMA_RD) ? mem_data_i : '0;
  assign cpu_rdata_o  = (r_state == S_CPU_RD) ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory
// and reference model; directed scenarios followed by randomized traffic.
module tb_mem_arbiter;

  localparam int LIM = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        dma_req_i = 1'b0, dma_we_i = 1'b0;
  logic [31:0] dma_addr_i = '0, dma_wdata_i = '0;
  logic        dma_gnt_o, dma_rvalid_o;
  logic [31:0] dma_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        mem_wren_o;
  logic [31:0] mem_data_i = '0;

  mem_arbiter #(.DATA_W(32), .STARVE_LIM(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
    .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_wren_o(mem_wren_o), .mem_data_i(mem_data_i)
  );

  always #5 CLK = ~CLK;

  // Data memory manager: synchronous read, one-cycle latency.
  logic [31:0] mem [16];
  always @(posedge CLK) begin
    if (mem_wren_o) mem[mem_addr_o[3:0]] <= mem_data_o;
    mem_data_i <= mem[mem_addr_o[3:0]];
  end

  typedef struct {
    logic        stall, gnt, wren, rvalid;
    logic [31:0] addr, data, drdata, crdata;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [16];
  int          streak = 0;
  int          pend_kind = 0;
  logic [31:0] pend_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected snapshot per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cpu_stall", 32'(cpu_stall_o), 32'(e.stall));
        check("dma_gnt", 32'(dma_gnt_o), 32'(e.gnt));
        check("mem_wren", 32'(mem_wren_o), 32'(e.wren));
        check("mem_addr", mem_addr_o, e.addr);
        check("mem_data", mem_data_o, e.data);
        check("dma_rvalid", 32'(dma_rvalid_o), 32'(e.rvalid));
        check("dma_rdata", dma_rdata_o, e.drdata);
        check("cpu_rdata", cpu_rdata_o, e.crdata);
      end
    end
  end

  // Drives one cycle of stimulus and predicts what the arbiter must show.
  task automatic cycle(input logic rv, input logic c, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic d, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    exp_t e;
    int   own;
    @(posedge CLK);
    #1;
    RST = rv;
    cpu_req_i = c; cpu_we_i = cw; cpu_addr_i = ca; cpu_wdata_i = cd;
    dma_req_i = d; dma_we_i = dw; dma_addr_i = da; dma_wdata_i = dd;
    if (!rv) begin
      streak = 0;
      pend_kind = 0;
    end
    e.rvalid = (pend_kind == 2);
    e.drdata = (pend_kind == 2) ? pend_data : 32'd0;
    e.crdata = (pend_kind == 1) ? pend_data : 32'd0;
    if (c && d) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      own = (streak == LIM) ? 2 : 1;
`else
      own = 1;
`endif
    end else own = c ? 1 : (d ? 2 : 0);
    e.gnt   = (own == 2);
    e.stall = c && (own != 1);
    e.wren  = (own == 1) ? cw : (own == 2) ? dw : 1'b0;
    e.addr  = (own == 1) ? ca : (own == 2) ? da : 32'd0;
    e.data  = (own == 1) ? cd : (own == 2) ? dd : 32'd0;
    pend_kind = 0;
    if (rv && own == 1 && !cw) pend_kind = 1;
    if (rv && own == 2 && !dw) pend_kind = 2;
    if (pend_kind != 0) pend_data = ref_mem[e.addr[3:0]];
    streak = (rv && c && d && own == 1) ? streak + 1 : 0;
    if (e.wren) ref_mem[e.addr[3:0]] = e.data;
    q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h1000 + 32'(i);
      ref_mem[i] = 32'h1000 + 32'(i);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 3, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 5, 32'hA5, 0, 0, 0, 0);
    cycle(1, 1, 0, 5, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 1, 7, 32'h1234);
    cycle(1, 0, 0, 0, 0, 1, 0, 7, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 32'(i % 16), 0, 1, 0, 7, 0);
    cycle(1, 0, 0, 0, 0, 1, 0, 7, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 2, 0, 1, 1, 9, 32'hBEEF);
    cycle(0, 1, 0, 2, 0, 1, 1, 9, 32'hBEEF);
    for (int i = 0; i < 12; i++) cycle(1, 1, 1, 32'(i), 32'hC0DE0000 + 32'(i), 1, 1, 4, 32'hD0);
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 49) != 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 15)), $urandom);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    @(posedge CLK);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0 pending snapshots", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data and address width.
REQ-002 SHALL have parameter STARVE_LIM, default 4, meaning consecutive contended cycles the CPU may win before the DMA is forced a slot (range 1..15).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_req_i, cpu_we_i  input  1 each  MEM-stage access request and write enable.
REQ-006 SHALL have ports cpu_addr_i, cpu_wdata_i  input  DATA_W each  MEM-stage address (ALU result) and store data.
REQ-007 SHALL have ports cpu_rdata_o  output  DATA_W  load data; cpu_stall_o  output  1  freeze request to the EX/MEM and MEM/WB pipes.
REQ-008 SHALL have ports dma_req_i, dma_we_i  input  1 each; dma_addr_i, dma_wdata_i  input  DATA_W each  secondary requester.
REQ-009 SHALL have ports dma_gnt_o  output  1; dma_rvalid_o  output  1; dma_rdata_o  output  DATA_W.
REQ-010 SHALL have ports mem_addr_o, mem_data_o  output  DATA_W; mem_wren_o  output  1; mem_data_i  input  DATA_W  to/from the data memory manager (synchronous read, 1-cycle latency).

Function
REQ-011 SHALL select one owner per cycle combinationally: NONE, CPU or DMA; mem_addr_o/mem_data_o/mem_wren_o SHALL mirror the owner's addr/wdata/we.
REQ-012 With owner NONE, mem_wren_o SHALL be 0, mem_addr_o and mem_data_o SHALL be 0.
REQ-013 Only CPU requesting: owner CPU; only DMA requesting: owner DMA.
REQ-014 Both requesting: owner CPU unless starve counter equals STARVE_LIM, then owner DMA.
REQ-015 Starve counter (4 bits) SHALL increment when both request and CPU owns; clear when DMA owns or dma_req_i is 0; never exceed STARVE_LIM.
REQ-016 cpu_stall_o SHALL be 1 exactly when cpu_req_i=1 and owner is not CPU (same cycle).
REQ-017 dma_gnt_o SHALL be 1 exactly when owner is DMA (same cycle); a write completes in that cycle.
REQ-018 SHALL register last-read owner state {IDLE, CPU_RD, DMA_RD}: next state CPU_RD on CPU read grant, DMA_RD on DMA read grant, else IDLE.
REQ-019 dma_rvalid_o SHALL be 1 in state DMA_RD, dma_rdata_o SHALL equal mem_data_i then and 0 otherwise.
REQ-020 cpu_rdata_o SHALL equal mem_data_i in state CPU_RD and 0 otherwise.
REQ-021 Back-to-back grants SHALL be allowed every cycle; no bubble between owners.
REQ-022 Write grants SHALL never produce rvalid or rdata.

Reset
REQ-023 While RST=0: state IDLE, starve counter 0, dma_rvalid_o 0, cpu_rdata_o 0, dma_rdata_o 0.
REQ-024 Reset asserted mid-read SHALL discard the pending read; no rvalid after release.
REQ-025 Combinational outputs during reset SHALL follow REQ-011..017 with counter forced 0.

Configuration
REQ-026 Macro MEM_ARB_STARVE_GUARD_EN defined: starve counter and forced DMA slot per REQ-014/015 are built.
REQ-027 Macro absent: no counter; CPU always wins contention; DMA granted only when cpu_req_i=0.

Verification
REQ-028 CPU write addr 5 data 0xA5, DMA idle -> mem_wren_o=1, mem_addr_o=5, mem_data_o=0xA5, cpu_stall_o=0.
REQ-029 CPU read addr 5 after 0xA5 stored -> next cycle cpu_rdata_o=0xA5, dma_rvalid_o=0.
REQ-030 Both request continuously, STARVE_LIM=4, guard enabled -> CPU owns cycles 0-3, DMA owns cycle 4 with cpu_stall_o=1, pattern repeats every 5 cycles.
REQ-031 Same stimulus, guard disabled -> dma_gnt_o stays 0 and cpu_stall_o stays 0 for 20 cycles.
REQ-032 DMA read addr 7 holding 0x1234 -> dma_gnt_o=1 cycle N, dma_rvalid_o=1 and dma_rdata_o=0x1234 cycle N+1.
REQ-033 RST low one cycle after DMA read grant -> dma_rvalid_o stays 0; counter reads 0 after release.
